// File: rtl/aes_io_pkg.sv
// Shared constants and state encoding for the result output path.
package aes_io_pkg;
  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = BLOCK_W / BYTE_W;
  localparam int CNT_W   = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} ser_state_t;
endpackage

// File: rtl/result_hold_reg.sv
// One-deep pending buffer for a result that arrives while a word is being sent.
// Sticky overflow records a write that found the buffer full and not being drained.
module result_hold_reg
  import aes_io_pkg::*;
#(
  parameter int W = BLOCK_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         rd,
  input  logic         clr_ovf,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         ovf
);
  logic drop;

  // A read in the same cycle frees the slot, so the write still lands.
  assign drop = wr & full & ~rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      full <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (wr && (!full || rd)) dout <= din;
      if (wr)      full <= 1'b1;
      else if (rd) full <= 1'b0;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end
endmodule

// File: rtl/result_serializer.sv
// Streams a captured Result word out as BYTE_W-wide bytes over a valid/ready link,
// with a one-deep pending buffer and sticky overflow for dropped words.
module result_serializer #(
  parameter int BLOCK_W   = aes_io_pkg::BLOCK_W,
  parameter int BYTE_W    = aes_io_pkg::BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [BLOCK_W-1:0] Result,
  input  logic               Ry,
  output logic [BYTE_W-1:0]  TxData,
  output logic               TxValid,
  input  logic               TxReady,
  output logic               Busy,
  output logic               Done,
  output logic               Ovf,
  input  logic               ClrOvf
);
  import aes_io_pkg::*;

  localparam int NB = BLOCK_W / BYTE_W;
  localparam int CW = $clog2(NB);

  ser_state_t         state, state_nxt;
  logic [BLOCK_W-1:0] sr, load_word, hold_dout;
  logic [CW-1:0]      cnt;
  logic               load, shift;
  logic               hold_wr, hold_rd, hold_full;
  logic [BYTE_W-1:0]  byte_out;

  assign hold_wr = Ry & (state != S_IDLE);

  result_hold_reg #(.W(BLOCK_W)) u_hold (
    .clk     (Clk),
    .rst_n   (Rst),
    .wr      (hold_wr),
    .rd      (hold_rd),
    .clr_ovf (ClrOvf),
    .din     (Result),
    .dout    (hold_dout),
    .full    (hold_full),
    .ovf     (Ovf)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    load_word = Result;
    hold_rd   = 1'b0;
    case (state)
      S_IDLE: if (Ry) begin
        state_nxt = S_SEND;
        load      = 1'b1;
      end
      S_SEND: if (TxReady) begin
        shift = 1'b1;
        if (cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: if (hold_full) begin
        // Back-to-back restart straight from the pending buffer, no IDLE cycle.
        state_nxt = S_SEND;
        load      = 1'b1;
        load_word = hold_dout;
        hold_rd   = 1'b1;
      end else begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_word;
      cnt <= CW'(NB - 1);
    end else if (shift) begin
      sr  <= MSB_FIRST ? (sr << BYTE_W) : (sr >> BYTE_W);
      cnt <= cnt - CW'(1);
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb
      assign byte_out = sr[BLOCK_W-1 -: BYTE_W];
    end else begin : g_lsb
      assign byte_out = sr[BYTE_W-1:0];
    end
  endgenerate

  // Outputs decode flops only, so reset clears them without waiting for Clk.
  assign TxValid = (state == S_SEND);
  assign TxData  = TxValid ? byte_out : '0;
  assign Done    = (state == S_DONE);
  assign Busy    = (state != S_IDLE) | hold_full;
endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: MSB-first and LSB-first instances share stimulus.
module tb_result_serializer;
  logic         Clk = 1'b0, Rst = 1'b0, Ry = 1'b0, TxReady = 1'b1, ClrOvf = 1'b0;
  logic [127:0] Result = '0;
  logic [7:0]   m_txdata, l_txdata;
  logic         m_txvalid, m_busy, m_done, m_ovf;
  logic         l_txvalid, l_busy, l_done, l_ovf;
  int nvec = 0, nerr = 0;

  localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] WA = {16{8'hA5}};
  localparam logic [127:0] WC = {16{8'hC3}};
  localparam logic [127:0] WN = 128'h01020304_05060708_090A0B0C_0D0E0F10;

  result_serializer #(.BLOCK_W(128), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .Rst(Rst), .Result(Result), .Ry(Ry), .TxData(m_txdata), .TxValid(m_txvalid),
    .TxReady(TxReady), .Busy(m_busy), .Done(m_done), .Ovf(m_ovf), .ClrOvf(ClrOvf));

  result_serializer #(.BLOCK_W(128), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_l (
    .Clk(Clk), .Rst(Rst), .Result(Result), .Ry(Ry), .TxData(l_txdata), .TxValid(l_txvalid),
    .TxReady(TxReady), .Busy(l_busy), .Done(l_done), .Ovf(l_ovf), .ClrOvf(ClrOvf));

  always #5 Clk = ~Clk;

  function automatic logic [7:0] eb(input logic [127:0] w, input int i, input bit msb);
    if (msb) return w[127-8*i -: 8];
    return w[8*i +: 8];
  endfunction

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    #3;
    nvec++;
    if ({m_txvalid, m_busy, m_done, m_ovf, m_txdata} !== 12'h0) begin
      nerr++; $display("FAIL reset_m got v%b b%b d%b o%b data %h exp all 0", m_txvalid, m_busy, m_done, m_ovf, m_txdata);
    end
    nvec++;
    if ({l_txvalid, l_busy, l_done, l_ovf, l_txdata} !== 12'h0) begin
      nerr++; $display("FAIL reset_l got v%b b%b d%b o%b data %h exp all 0", l_txvalid, l_busy, l_done, l_ovf, l_txdata);
    end
    step(); step();
    Rst = 1'b1;
    step();
  endtask

  task automatic test_msb_stream();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(W1, i, 1'b1)) begin
        nerr++; $display("FAIL t1_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(W1, i, 1'b1));
      end
      step();
    end
    @(negedge Clk); nvec++;
    if ({m_done, m_txvalid, m_busy, m_txdata} !== {3'b101, 8'h00}) begin
      nerr++; $display("FAIL t1_done got d%b v%b b%b %h exp d1 v0 b1 00", m_done, m_txvalid, m_busy, m_txdata);
    end
    step();
    @(negedge Clk); nvec++;
    if ({m_busy, m_done} !== 2'b00) begin
      nerr++; $display("FAIL t1_idle got b%b d%b exp b0 d0", m_busy, m_done);
    end
    step();
  endtask

  task automatic test_backpressure();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        TxReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge Clk); nvec++;
          if (m_txvalid !== 1'b1 || m_txdata !== 8'h22) begin
            nerr++; $display("FAIL t2_stall%0d got v%b %h exp v1 22", k, m_txvalid, m_txdata);
          end
          step();
        end
        TxReady = 1'b1;
      end
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(W1, i, 1'b1)) begin
        nerr++; $display("FAIL t2_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(W1, i, 1'b1));
      end
      step();
    end
    @(negedge Clk); nvec++;
    if (m_done !== 1'b1) begin
      nerr++; $display("FAIL t2_done got %b exp 1", m_done);
    end
    step();
  endtask

  task automatic test_pending();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(W1, i, 1'b1)) begin
        nerr++; $display("FAIL t3_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(W1, i, 1'b1));
      end
      if (i == 4) begin Ry = 1'b1; Result = WA; end
      step(); Ry = 1'b0;
    end
    @(negedge Clk); nvec++;
    if ({m_done, m_busy, m_txvalid} !== 3'b110) begin
      nerr++; $display("FAIL t3_done got d%b b%b v%b exp d1 b1 v0", m_done, m_busy, m_txvalid);
    end
    step();
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== 8'hA5) begin
        nerr++; $display("FAIL t3_a5_byte%0d got v%b %h exp v1 a5", i, m_txvalid, m_txdata);
      end
      step();
    end
    @(negedge Clk); nvec++;
    if ({m_done, m_ovf} !== 2'b10) begin
      nerr++; $display("FAIL t3_done2 got d%b o%b exp d1 o0", m_done, m_ovf);
    end
    step();
    @(negedge Clk); nvec++;
    if (m_busy !== 1'b0) begin
      nerr++; $display("FAIL t3_idle got busy %b exp 0", m_busy);
    end
    step();
  endtask

  task automatic test_overflow();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(W1, i, 1'b1)) begin
        nerr++; $display("FAIL t4_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(W1, i, 1'b1));
      end
      if (i == 6 || i == 7) begin
        nvec++;
        if (m_ovf !== (i == 7)) begin
          nerr++; $display("FAIL t4_ovf_at%0d got %b exp %b", i, m_ovf, (i == 7));
        end
      end
      if (i == 4) begin Ry = 1'b1; Result = WA; end
      if (i == 6) begin Ry = 1'b1; Result = WC; end
      step(); Ry = 1'b0;
    end
    @(negedge Clk); step();
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== 8'hA5) begin
        nerr++; $display("FAIL t4_a5_byte%0d got v%b %h exp v1 a5", i, m_txvalid, m_txdata);
      end
      step();
    end
    step();
    @(negedge Clk); nvec++;
    if ({m_busy, m_txvalid, m_ovf} !== 3'b001) begin
      nerr++; $display("FAIL t4_no_third got b%b v%b o%b exp b0 v0 o1", m_busy, m_txvalid, m_ovf);
    end
    ClrOvf = 1'b1; step(); ClrOvf = 1'b0;
    @(negedge Clk); nvec++;
    if (m_ovf !== 1'b0) begin
      nerr++; $display("FAIL t4_clr got %b exp 0", m_ovf);
    end
    step();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i == 2) begin Ry = 1'b1; Result = WA; end
      if (i == 3) begin Ry = 1'b1; Result = WC; ClrOvf = 1'b1; end
      step(); Ry = 1'b0; ClrOvf = 1'b0;
    end
    @(negedge Clk); nvec++;
    if (m_ovf !== 1'b1) begin
      nerr++; $display("FAIL t4_set_wins got %b exp 1", m_ovf);
    end
    for (int k = 0; k < 100 && m_busy; k++) step();
    @(negedge Clk); nvec++;
    if (m_busy !== 1'b0) begin
      nerr++; $display("FAIL t4_drain got busy %b exp 0 within 100 cycles", m_busy);
    end
    ClrOvf = 1'b1; step(); ClrOvf = 1'b0;
  endtask

  task automatic test_reset_abort();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(W1, i, 1'b1)) begin
        nerr++; $display("FAIL t5_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(W1, i, 1'b1));
      end
      if (i == 4) begin
        nvec++;
        if (m_ovf !== 1'b1) begin
          nerr++; $display("FAIL t5_ovf_pre got %b exp 1", m_ovf);
        end
      end
      if (i == 5) break;
      if (i == 1) begin Ry = 1'b1; Result = WA; end
      if (i == 2) begin Ry = 1'b1; Result = WC; end
      step(); Ry = 1'b0;
    end
    #2; Rst = 1'b0; Ry = 1'b1; Result = WC;
    #1; nvec++;
    if ({m_txvalid, m_busy, m_ovf, m_txdata} !== 11'h0) begin
      nerr++; $display("FAIL t5_async got v%b b%b o%b %h exp all 0", m_txvalid, m_busy, m_ovf, m_txdata);
    end
    @(negedge Clk); Rst = 1'b1; Ry = 1'b0;
    step();
    @(negedge Clk); nvec++;
    if ({m_txvalid, m_busy} !== 2'b00) begin
      nerr++; $display("FAIL t5_ry_in_reset got v%b b%b exp v0 b0", m_txvalid, m_busy);
    end
    Ry = 1'b1; Result = WN; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (m_txvalid !== 1'b1 || m_txdata !== eb(WN, i, 1'b1)) begin
        nerr++; $display("FAIL t5_new_byte%0d got v%b %h exp v1 %h", i, m_txvalid, m_txdata, eb(WN, i, 1'b1));
      end
      step();
    end
    @(negedge Clk); nvec++;
    if (m_done !== 1'b1) begin
      nerr++; $display("FAIL t5_done got %b exp 1", m_done);
    end
    step(); step();
  endtask

  task automatic test_lsb_first();
    Ry = 1'b1; Result = W1; step(); Ry = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk); nvec++;
      if (l_txvalid !== 1'b1 || l_txdata !== eb(W1, i, 1'b0)) begin
        nerr++; $display("FAIL t6_byte%0d got v%b %h exp v1 %h", i, l_txvalid, l_txdata, eb(W1, i, 1'b0));
      end
      step();
    end
    @(negedge Clk); nvec++;
    if ({l_done, l_txvalid, l_busy} !== 3'b101) begin
      nerr++; $display("FAIL t6_done got d%b v%b b%b exp d1 v0 b1", l_done, l_txvalid, l_busy);
    end
    step();
    @(negedge Clk); nvec++;
    if ({l_busy, l_done} !== 2'b00) begin
      nerr++; $display("FAIL t6_idle got b%b d%b exp b0 d0", l_busy, l_done);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_msb_stream();
    test_backpressure();
    test_pending();
    test_overflow();
    test_reset_abort();
    test_lsb_first();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
